// File: rtl/cpu_defs_pkg.sv
// cpu_defs: shared opcode, ALU and control-bit definitions for the decode stage
package cpu_defs;
  localparam logic [5:0] OP_SPECIAL = 6'b000000;
  localparam logic [5:0] OP_ORI     = 6'b001101;
  localparam logic [5:0] OP_ADDIU   = 6'b001001;
  localparam logic [5:0] OP_LUI     = 6'b001111;
  localparam logic [5:0] OP_LW      = 6'b100011;
  localparam logic [5:0] OP_SW      = 6'b101011;
  localparam logic [5:0] FN_OR      = 6'b100101;
  localparam logic [5:0] FN_ADDU    = 6'b100001;
  localparam logic [4:0] ALU_OR     = 5'b00001;
  localparam logic [4:0] ALU_ADD    = 5'b00010;
  localparam logic [4:0] ALU_NOP    = 5'b11111;
  localparam int CTRL_W        = 13;
  localparam int CTRL_REGWRITE = 12;
  localparam int CTRL_REGDST   = 11;
  localparam int CTRL_ALUSRC   = 10;
  localparam int CTRL_MEMTOREG = 9;
  localparam int CTRL_MEMWRITE = 8;
  localparam int CTRL_MEMREAD  = 7;
endpackage

// File: rtl/id_stage_regfile.sv
// regfile: 32x32 register file, two read ports, one write port with write-through bypass
module regfile (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  input  logic        we,
  input  logic [4:0]  wa,
  input  logic [31:0] wd,
  output logic [31:0] rd1,
  output logic [31:0] rd2
);
  logic [31:0] mem [32];
  logic        wr;
  assign wr  = we && wa != 5'd0;
  assign rd1 = ra1 == 5'd0 ? 32'd0 : (wr && wa == ra1) ? wd : mem[ra1];
  assign rd2 = ra2 == 5'd0 ? 32'd0 : (wr && wa == ra2) ? wd : mem[ra2];
  // storage: cleared on reset, r0 never written
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) mem[i] <= '0;
    end else if (wr) begin
      mem[wa] <= wd;
    end
  end
endmodule

// File: rtl/id_stage.sv
// id_stage: IF/ID register, decode, register read and stall-based hazard handling
module id_stage
  import cpu_defs::*;
#(
  parameter logic [31:0] RESET_PC = 32'hbfc00000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_valid,
  input  logic [31:0]       if_pc,
  input  logic [31:0]       if_inst,
  input  logic              flush,
  input  logic              ex_regwrite,
  input  logic [4:0]        ex_writereg,
  input  logic              mem_regwrite,
  input  logic [4:0]        mem_writereg,
  input  logic              wb_regwrite,
  input  logic [4:0]        wb_writereg,
  input  logic [31:0]       wb_wdata,
  output logic              stall,
  output logic [31:0]       pc,
  output logic [31:0]       srca,
  output logic [31:0]       srcb,
  output logic [31:0]       extend_imm,
  output logic [CTRL_W-1:0] controls,
  output logic [4:0]        alucontrol,
  output logic [4:0]        rs,
  output logic [4:0]        rt,
  output logic [4:0]        rd
);
  logic              d_valid;
  logic [31:0]       d_pc, d_inst;
  logic [5:0]        op, fn;
  logic [15:0]       imm;
  logic              is_or, is_addu, is_ori, is_addiu, is_lui, is_lw, is_sw, known;
  logic              rs_used, rt_used, rs_hit, rt_hit, hazard, bubble;
  logic [CTRL_W-1:0] ctl;
  logic [4:0]        alu;
  logic [31:0]       ext;
  // IF/ID pipeline register: flush beats stall
  always_ff @(posedge clk) begin
    if (reset) begin
      d_valid <= 1'b0;
      d_pc    <= RESET_PC;
      d_inst  <= '0;
    end else if (flush) begin
      d_valid <= 1'b0;
    end else if (!stall) begin
      d_valid <= if_valid;
      d_pc    <= if_pc;
      d_inst  <= if_inst;
    end
  end
  assign op       = d_inst[31:26];
  assign fn       = d_inst[5:0];
  assign imm      = d_inst[15:0];
  assign rs       = d_inst[25:21];
  assign rt       = d_inst[20:16];
  assign rd       = d_inst[15:11];
  assign is_or    = op == OP_SPECIAL && fn == FN_OR;
  assign is_addu  = op == OP_SPECIAL && fn == FN_ADDU;
  assign is_ori   = op == OP_ORI;
  assign is_addiu = op == OP_ADDIU;
  assign is_lui   = op == OP_LUI;
  assign is_lw    = op == OP_LW;
  assign is_sw    = op == OP_SW;
  assign known    = is_or | is_addu | is_ori | is_addiu | is_lui | is_lw | is_sw;
  assign rs_used  = is_or | is_addu | is_ori | is_addiu | is_lw | is_sw;
  assign rt_used  = is_or | is_addu | is_sw;
  assign rs_hit   = rs != 5'd0 && ((ex_regwrite && ex_writereg == rs) || (mem_regwrite && mem_writereg == rs));
  assign rt_hit   = rt != 5'd0 && ((ex_regwrite && ex_writereg == rt) || (mem_regwrite && mem_writereg == rt));
  assign hazard   = d_valid && ((rs_used && rs_hit) || (rt_used && rt_hit));
  assign stall    = hazard && !flush;
  assign bubble   = !d_valid || hazard || flush || !known;
  // raw decode of the held instruction, before bubble masking
  always_comb begin
    ctl                = '0;
    ctl[CTRL_REGWRITE] = is_or | is_addu | is_ori | is_addiu | is_lui | is_lw;
    ctl[CTRL_REGDST]   = is_or | is_addu;
    ctl[CTRL_ALUSRC]   = is_ori | is_addiu | is_lui | is_lw | is_sw;
    ctl[CTRL_MEMTOREG] = is_lw;
    ctl[CTRL_MEMWRITE] = is_sw;
    ctl[CTRL_MEMREAD]  = is_lw;
    alu = (is_or | is_ori | is_lui) ? ALU_OR : (is_addu | is_addiu | is_lw | is_sw) ? ALU_ADD : ALU_NOP;
    ext = is_ori ? {16'd0, imm} : is_lui ? {imm, 16'd0} : (is_addiu | is_lw | is_sw) ? {{16{imm[15]}}, imm} : 32'd0;
  end
  assign pc         = d_pc;
  assign controls   = bubble ? '0 : ctl;
  assign alucontrol = bubble ? ALU_NOP : alu;
  assign extend_imm = bubble ? 32'd0 : ext;
  regfile u_rf (
    .clk  (clk),
    .reset(reset),
    .ra1  (rs),
    .ra2  (rt),
    .we   (wb_regwrite),
    .wa   (wb_writereg),
    .wd   (wb_wdata),
    .rd1  (srca),
    .rd2  (srcb)
  );
endmodule

// File: tb/tb_id_stage.sv
// tb_id_stage: scoreboard-driven checks of decode, stalls, bypass, flush and reset
module tb_id_stage;
  import cpu_defs::*;
  localparam logic [31:0] RPC = 32'hbfc00000;
  logic        clk = 0, reset = 1, if_valid = 0, flush = 0;
  logic [31:0] if_pc = 0, if_inst = 0, wb_wdata = 0;
  logic        ex_regwrite = 0, mem_regwrite = 0, wb_regwrite = 0;
  logic [4:0]  ex_writereg = 0, mem_writereg = 0, wb_writereg = 0;
  logic        stall;
  logic [31:0] pc, srca, srcb, extend_imm;
  logic [12:0] controls;
  logic [4:0]  alucontrol, rs, rt, rd;
  logic [87:0] obs;
  typedef struct { string nm; logic [87:0] v; } exp_t;
  exp_t sb[$];
  exp_t e;
  int total = 0, bad = 0;
  id_stage dut (
    .clk(clk), .reset(reset), .if_valid(if_valid), .if_pc(if_pc), .if_inst(if_inst), .flush(flush),
    .ex_regwrite(ex_regwrite), .ex_writereg(ex_writereg), .mem_regwrite(mem_regwrite), .mem_writereg(mem_writereg),
    .wb_regwrite(wb_regwrite), .wb_writereg(wb_writereg), .wb_wdata(wb_wdata),
    .stall(stall), .pc(pc), .srca(srca), .srcb(srcb), .extend_imm(extend_imm), .controls(controls),
    .alucontrol(alucontrol), .rs(rs), .rt(rt), .rd(rd)
  );
  always #5 clk = ~clk;
  assign obs = {pc, controls, alucontrol, extend_imm, stall, rt};
  task automatic load(input logic [31:0] inst, input logic [31:0] p);
    if_valid = 1; if_inst = inst; if_pc = p;
    @(posedge clk); #1;
    if_valid = 0; #1;
  endtask
  task automatic test_reset;
    reset = 1;
    repeat (2) @(posedge clk);
    #1 reset = 0;
    sb.push_back('{"reset", {RPC, 13'h0, ALU_NOP, 32'h0, 1'b0, 5'd0}});
    #1 e = sb.pop_front(); total++;
    if (obs !== e.v) begin bad++; $display("FAIL %s got=%h need=%h", e.nm, obs, e.v); end
  endtask
  task automatic test_imm;
    load(32'h34018000, 32'h100);
    sb.push_back('{"ori", {32'h100, 13'h1400, ALU_OR, 32'h00008000, 1'b0, 5'd1}});
    e = sb.pop_front(); total++;
    if (obs !== e.v) begin bad++; $display("FAIL %s got=%h need=%h", e.nm, obs, e.v); end
    load(32'h2402fffc, 32'h104);
    sb.push_back('{"addiu", {32'h104, 13'h1400, ALU_ADD, 32'hfffffffc, 1'b0, 5'd2}});
    e = sb.pop_front(); total++;
    if (obs !== e.v) begin bad++; $display("FAIL %s got=%h need=%h", e.nm, obs, e.v); end
    load(32'h3c031234, 32'h108);
    sb.push_back('{"lui", {32'h108, 13'h1400, ALU_OR, 32'h12340000, 1'b0, 5'd3}});
    e = sb.pop_front(); total++;
    if (obs !== e.v) begin bad++; $display("FAIL %s got=%h need=%h", e.nm, obs, e.v); end
  endtask
  task automatic test_dependency;
    load(32'h00222025, 32'h200);
    ex_regwrite = 1; ex_writereg = 1;
    sb.push_back('{"dep_ex", {32'h200, 13'h0, ALU_NOP, 32'h0, 1'b1, 5'd2}});
    #1 e = sb.pop_front(); total++;
    if (obs !== e.v) begin bad++; $display("FAIL %s got=%h need=%h", e.nm, obs, e.v); end
    @(posedge clk); #1;
    ex_regwrite = 0; mem_regwrite = 1; mem_writereg = 1;
    sb.push_back('{"dep_mem", {32'h200, 13'h0, ALU_NOP, 32'h0, 1'b1, 5'd2}});
    #1 e = sb.pop_front(); total++;
    if (obs !== e.v) begin bad++; $display("FAIL %s got=%h need=%h", e.nm, obs, e.v); end
    @(posedge clk); #1;
    mem_regwrite = 0; wb_regwrite = 1; wb_writereg = 1; wb_wdata = 32'h8000;
    sb.push_back('{"dep_wb", {32'h200, 13'h1800, ALU_OR, 32'h0, 1'b0, 5'd2}});
    #1 e = sb.pop_front(); total++;
    if (obs !== e.v) begin bad++; $display("FAIL %s got=%h need=%h", e.nm, obs, e.v); end
    total++;
    if (srca !== 32'h8000) begin bad++; $display("FAIL dep_bypass srca got=%h need=%h", srca, 32'h8000); end
    @(posedge clk); #1;
    wb_regwrite = 0; #1;
    total++;
    if (srca !== 32'h8000) begin bad++; $display("FAIL dep_written srca got=%h need=%h", srca, 32'h8000); end
  endtask
  task automatic test_r0;
    wb_regwrite = 1; wb_writereg = 0; wb_wdata = 32'hffffffff;
    load(32'h34050000, 32'h300);
    total++;
    if (srca !== 32'h0) begin bad++; $display("FAIL r0_bypass srca got=%h need=0", srca); end
    wb_regwrite = 0; ex_regwrite = 1; ex_writereg = 0;
    sb.push_back('{"r0_nostall", {32'h300, 13'h1400, ALU_OR, 32'h0, 1'b0, 5'd5}});
    #1 e = sb.pop_front(); total++;
    if (obs !== e.v) begin bad++; $display("FAIL %s got=%h need=%h", e.nm, obs, e.v); end
    total++;
    if (srca !== 32'h0) begin bad++; $display("FAIL r0_read srca got=%h need=0", srca); end
    ex_regwrite = 0;
  endtask
  task automatic test_flush;
    load(32'h00222025, 32'h400);
    ex_regwrite = 1; ex_writereg = 2;
    sb.push_back('{"flush_pre", {32'h400, 13'h0, ALU_NOP, 32'h0, 1'b1, 5'd2}});
    #1 e = sb.pop_front(); total++;
    if (obs !== e.v) begin bad++; $display("FAIL %s got=%h need=%h", e.nm, obs, e.v); end
    flush = 1;
    sb.push_back('{"flush_now", {32'h400, 13'h0, ALU_NOP, 32'h0, 1'b0, 5'd2}});
    #1 e = sb.pop_front(); total++;
    if (obs !== e.v) begin bad++; $display("FAIL %s got=%h need=%h", e.nm, obs, e.v); end
    @(posedge clk); #1;
    flush = 0;
    sb.push_back('{"flush_after", {32'h400, 13'h0, ALU_NOP, 32'h0, 1'b0, 5'd2}});
    #1 e = sb.pop_front(); total++;
    if (obs !== e.v) begin bad++; $display("FAIL %s got=%h need=%h", e.nm, obs, e.v); end
    ex_regwrite = 0;
  endtask
  task automatic test_unknown;
    load(32'hfc000000, 32'h500);
    sb.push_back('{"unknown", {32'h500, 13'h0, ALU_NOP, 32'h0, 1'b0, 5'd0}});
    e = sb.pop_front(); total++;
    if (obs !== e.v) begin bad++; $display("FAIL %s got=%h need=%h", e.nm, obs, e.v); end
  endtask
  task automatic test_back_to_back;
    if_valid = 1; if_inst = 32'h8c220004; if_pc = 32'h600;
    sb.push_back('{"lw", {32'h600, 13'h1680, ALU_ADD, 32'h4, 1'b0, 5'd2}});
    sb.push_back('{"sw", {32'h604, 13'h0500, ALU_ADD, 32'hfffffff8, 1'b0, 5'd2}});
    @(posedge clk); #1;
    if_inst = 32'hac22fff8; if_pc = 32'h604;
    #1 e = sb.pop_front(); total++;
    if (obs !== e.v) begin bad++; $display("FAIL %s got=%h need=%h", e.nm, obs, e.v); end
    @(posedge clk); #1;
    if_valid = 0;
    #1 e = sb.pop_front(); total++;
    if (obs !== e.v) begin bad++; $display("FAIL %s got=%h need=%h", e.nm, obs, e.v); end
  endtask
  task automatic test_reset_mid_stall;
    load(32'h00222025, 32'h700);
    ex_regwrite = 1; ex_writereg = 1;
    #1 reset = 1;
    @(posedge clk); #1;
    reset = 0;
    sb.push_back('{"reset_stall", {RPC, 13'h0, ALU_NOP, 32'h0, 1'b0, 5'd0}});
    #1 e = sb.pop_front(); total++;
    if (obs !== e.v) begin bad++; $display("FAIL %s got=%h need=%h", e.nm, obs, e.v); end
    ex_regwrite = 0;
    load(32'h00222025, 32'h800);
    total++;
    if (srca !== 32'h0) begin bad++; $display("FAIL reset_rf srca got=%h need=0", srca); end
  endtask
  initial begin
    test_reset;
    test_imm;
    test_dependency;
    test_r0;
    test_flush;
    test_unknown;
    test_back_to_back;
    test_reset_mid_stall;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
